bcd_op_sequencer: RTL and testbench



---
 rtl/bcd_seq_pkg.sv | 31 +++
 rtl/hs_timeout_timer.sv | 31 +++
 rtl/bcd_op_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bcd_op_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_pkg.sv
// Shared types and helpers for the BCD operation sequencer.
package bcd_seq_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned CH_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    RST      = 4'd0,
    INIT_REQ = 4'd1,
    INIT_REL = 4'd2,
    IDLE     = 4'd3,
    LOAD_REQ = 4'd4,
    LOAD_REL = 4'd5,
    OPD_REQ  = 4'd6,
    OPD_REL  = 4'd7,
    DIG_REQ  = 4'd8,
    DIG_REL  = 4'd9
  } seqState_e;

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [CH_W-1:0] lowestSetIdx(input logic [MAX_CH-1:0] vec);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hs_timeout_timer.sv
// Per-phase handshake watchdog: counts enabled cycles since the last clear.
module hs_timeout_timer #(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned TIMEOUT_W   = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(ACK_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  // Cycle counter, cleared on state entry and saturating at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // Expiry is a same-cycle flag so the sequencer can abort on this edge.
  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/bcd_op_sequencer.sv
// Sequences operand loads, operand displays and result-digit displays over
// four-phase req/ack handshakes, with edge-detected buttons, fixed-priority
// arbitration and a sticky per-phase ack timeout.
module bcd_op_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int unsigned NUM_OPERANDS = 2,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned ACK_TIMEOUT  = 1024,
  parameter int unsigned TIMEOUT_W    = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_OPERANDS-1:0] load_btn,
  input  logic [NUM_DIGITS-1:0]   digit_btn,
  output logic                    init_req,
  input  logic                    init_ack,
  output logic [NUM_OPERANDS-1:0] load_req,
  input  logic [NUM_OPERANDS-1:0] load_ack,
  output logic [NUM_OPERANDS-1:0] opdisp_req,
  input  logic [NUM_OPERANDS-1:0] opdisp_ack,
  output logic [NUM_DIGITS-1:0]   digit_req,
  input  logic [NUM_DIGITS-1:0]   digit_ack,
  output logic                    busy,
  output logic                    error,
  output logic [STATE_W-1:0]      state_dbg
);

  seqState_e state;
  seqState_e stateNext;

  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] chNext;

  logic [NUM_OPERANDS-1:0] loadBtnQ;
  logic [NUM_DIGITS-1:0]   digitBtnQ;
  logic [NUM_OPERANDS-1:0] loadEvt;
  logic [NUM_DIGITS-1:0]   digitEvt;

  logic [NUM_OPERANDS-1:0] opSel;
  logic [NUM_DIGITS-1:0]   digSel;
  logic                    loadAckSel;
  logic                    opdAckSel;
  logic                    digitAckSel;

  logic timerClear;
  logic timerEnable;
  logic timerExpired;
  logic timeoutHit;

  // Button history for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loadBtnQ  <= '0;
      digitBtnQ <= '0;
    end else begin
      loadBtnQ  <= load_btn;
      digitBtnQ <= digit_btn;
    end
  end

  // Rising edges only; a held button produces a single event.
  always_comb begin
    loadEvt  = load_btn & ~loadBtnQ;
    digitEvt = digit_btn & ~digitBtnQ;
  end

  // Acks of the latched channel only; other channels are ignored.
  always_comb begin
    opSel       = NUM_OPERANDS'(1) << ch;
    digSel      = NUM_DIGITS'(1) << ch;
    loadAckSel  = |(load_ack & opSel);
    opdAckSel   = |(opdisp_ack & opSel);
    digitAckSel = |(digit_ack & digSel);
  end

  // The watchdog runs in every handshake phase and restarts on each state entry.
  always_comb begin
    timerEnable = (state != RST) && (state != IDLE);
    timerClear  = (stateNext != state);
  end

  hs_timeout_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TIMEOUT_W   (TIMEOUT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timerClear),
    .enable  (timerEnable),
    .expired (timerExpired)
  );

  // State and latched channel register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RST;
      ch    <= '0;
    end else begin
      state <= stateNext;
      ch    <= chNext;
    end
  end

  // Next-state logic: handshakes, arbitration in IDLE, timeout abort.
  always_comb begin
    stateNext  = state;
    chNext     = ch;
    timeoutHit = 1'b0;

    case (state)
      RST:      stateNext = INIT_REQ;
      INIT_REQ: if (init_ack)     stateNext = INIT_REL;
      INIT_REL: if (!init_ack)    stateNext = IDLE;
      IDLE: begin
        if (|loadEvt) begin
          chNext    = lowestSetIdx(MAX_CH'(loadEvt));
          stateNext = LOAD_REQ;
        end else if (|digitEvt) begin
          chNext    = lowestSetIdx(MAX_CH'(digitEvt));
          stateNext = DIG_REQ;
        end
      end
      LOAD_REQ: if (loadAckSel)   stateNext = LOAD_REL;
      LOAD_REL: if (!loadAckSel)  stateNext = OPD_REQ;
      OPD_REQ:  if (opdAckSel)    stateNext = OPD_REL;
      OPD_REL:  if (!opdAckSel)   stateNext = IDLE;
      DIG_REQ:  if (digitAckSel)  stateNext = DIG_REL;
      DIG_REL:  if (!digitAckSel) stateNext = IDLE;
      default:  stateNext = RST;
    endcase

    // A stuck phase abandons the whole transaction, including any pending display.
    if (timerExpired) begin
      stateNext  = IDLE;
      timeoutHit = 1'b1;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      init_req   <= 1'b0;
      load_req   <= '0;
      opdisp_req <= '0;
      digit_req  <= '0;
      busy       <= 1'b1;
      error      <= 1'b0;
      state_dbg  <= '0;
    end else begin
      init_req   <= (stateNext == INIT_REQ);
      load_req   <= (stateNext == LOAD_REQ) ? (NUM_OPERANDS'(1) << chNext) : '0;
      opdisp_req <= (stateNext == OPD_REQ)  ? (NUM_OPERANDS'(1) << chNext) : '0;
      digit_req  <= (stateNext == DIG_REQ)  ? (NUM_DIGITS'(1) << chNext)   : '0;
      busy       <= (stateNext != IDLE);
      error      <= error | timeoutHit;
      state_dbg  <= STATE_W'(stateNext);
    end
  end

endmodule

// File: tb/tb_bcd_op_sequencer.sv
// Randomized self-checking bench for bcd_op_sequencer with an echo responder.
module tb_bcd_op_sequencer;

  localparam int unsigned NOPS = 2;
  localparam int unsigned NDIG = 2;
  localparam int unsigned TMO  = 16;
  localparam int KIND_INIT = 0;
  localparam int KIND_LOAD = 1;
  localparam int KIND_OPD  = 2;
  localparam int KIND_DIG  = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [NOPS-1:0] load_btn;
  logic [NDIG-1:0] digit_btn;
  logic            init_req;
  logic            init_ack;
  logic [NOPS-1:0] load_req;
  logic [NOPS-1:0] load_ack;
  logic [NOPS-1:0] opdisp_req;
  logic [NOPS-1:0] opdisp_ack;
  logic [NDIG-1:0] digit_req;
  logic [NDIG-1:0] digit_ack;
  logic            busy;
  logic            error;
  logic [3:0]      state_dbg;

  int checkCount = 0;
  int passCount  = 0;

  int         ackDelay = 2;
  logic [6:0] ackMask  = 7'h7f;
  logic [6:0] hist [8] = '{default: '0};
  logic [6:0] ackVec;

  int         obs[$];
  int         expQ[$];
  logic [6:0] prevReq = '0;
  logic [6:0] curReq;
  int         loadLen = 0;
  int         lastLoadLen = 0;
  logic       expErr = 1'b0;

  bcd_op_sequencer #(
    .NUM_OPERANDS (NOPS),
    .NUM_DIGITS   (NDIG),
    .ACK_TIMEOUT  (TMO),
    .TIMEOUT_W    (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_btn   (load_btn),
    .digit_btn  (digit_btn),
    .init_req   (init_req),
    .init_ack   (init_ack),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .opdisp_req (opdisp_req),
    .opdisp_ack (opdisp_ack),
    .digit_req  (digit_req),
    .digit_ack  (digit_ack),
    .busy       (busy),
    .error      (error),
    .state_dbg  (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obsV, input logic [31:0] expV);
    checkCount++;
    if (obsV === expV) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obsV, expV);
  endtask

  // Responder: each ack echoes its req delayed by ackDelay-1 cycles, masked by ackMask.
  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      for (int i = 0; i < 8; i++) hist[i] = '0;
    end else begin
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {init_req, load_req, opdisp_req, digit_req};
    end
    ackVec     = hist[ackDelay-1] & ackMask;
    init_ack   = ackVec[6];
    load_ack   = ackVec[5:4];
    opdisp_ack = ackVec[3:2];
    digit_ack  = ackVec[1:0];
  end

  // Monitor: logs every request rise as kind*256+onehot and times load_req pulses.
  always @(negedge clock) begin
    curReq = {init_req, load_req, opdisp_req, digit_req};
    if (curReq[6] && !prevReq[6])                    obs.push_back(KIND_INIT * 256 + 1);
    if (curReq[5:4] != 0 && prevReq[5:4] == 0)       obs.push_back(KIND_LOAD * 256 + int'(curReq[5:4]));
    if (curReq[3:2] != 0 && prevReq[3:2] == 0)       obs.push_back(KIND_OPD * 256 + int'(curReq[3:2]));
    if (curReq[1:0] != 0 && prevReq[1:0] == 0)       obs.push_back(KIND_DIG * 256 + int'(curReq[1:0]));
    if (curReq[5:4] != 0) loadLen++;
    else if (prevReq[5:4] != 0) begin
      lastLoadLen = loadLen;
      loadLen     = 0;
    end
    prevReq = curReq;
  end

  function automatic int firstSet(input logic [1:0] v);
    int idx = -1;
    for (int i = 0; i < 2; i++) if (v[i] && idx < 0) idx = i;
    return idx;
  endfunction

  // Reference: what one button press seen in IDLE should produce.
  task automatic buildExpected(input logic [1:0] lp, input logic [1:0] dp, input bit loadDead);
    int idx;
    expQ.delete();
    if (lp != 0) begin
      idx = firstSet(lp);
      expQ.push_back(KIND_LOAD * 256 + (1 << idx));
      if (!loadDead) expQ.push_back(KIND_OPD * 256 + (1 << idx));
    end else if (dp != 0) begin
      idx = firstSet(dp);
      expQ.push_back(KIND_DIG * 256 + (1 << idx));
    end
  endtask

  task automatic compareObs(input string tag);
    checkVal({tag, "_count"}, 32'(obs.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obs.size(); i++)
      checkVal($sformatf("%s_txn%0d", tag, i), 32'(obs[i]), 32'(expQ[i]));
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkVal({tag, "_busy"}, 32'(busy), 32'(0));
    checkVal({tag, "_state"}, 32'(state_dbg), 32'(3));
  endtask

  // One press (optionally held, optionally followed by a press while busy).
  task automatic runTxn(input string tag, input logic [1:0] lp, input logic [1:0] dp,
                        input int hold, input bit extra, input bit loadDead);
    obs.delete();
    buildExpected(lp, dp, loadDead);
    load_btn  = lp;
    digit_btn = dp;
    repeat (hold) @(negedge clock);
    load_btn  = '0;
    digit_btn = '0;
    if (extra) begin
      @(negedge clock);
      if (busy) begin
        load_btn  = 2'($urandom_range(1, 3));
        digit_btn = 2'($urandom_range(1, 3));
        @(negedge clock);
        load_btn  = '0;
        digit_btn = '0;
      end
    end
    waitIdle(tag);
    repeat (3) @(negedge clock);
    compareObs(tag);
    checkVal({tag, "_err"}, 32'(error), 32'(expErr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset      = 1'b1;
    load_btn   = '0;
    digit_btn  = '0;
    init_ack   = 1'b0;
    load_ack   = '0;
    opdisp_ack = '0;
    digit_ack  = '0;

    // Reset state
    repeat (3) @(negedge clock);
    checkVal("rst_state", 32'(state_dbg), 32'(0));
    checkVal("rst_busy", 32'(busy), 32'(1));
    checkVal("rst_err", 32'(error), 32'(0));
    checkVal("rst_reqs", 32'({init_req, load_req, opdisp_req, digit_req}), 32'(0));

    // Init handshake
    ackDelay = 2;
    obs.delete();
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkVal("init_req", 32'(init_req), 32'(1));
    checkVal("init_state", 32'(state_dbg), 32'(1));
    @(negedge clock);
    waitIdle("init");
    expQ.delete();
    expQ.push_back(KIND_INIT * 256 + 1);
    compareObs("init");
    checkVal("init_err", 32'(error), 32'(0));

    // Directed: load of operand 1; simultaneous load/digit priority; held digit button
    runTxn("load1", 2'b10, 2'b00, 1, 1'b0, 1'b0);
    runTxn("prio", 2'b11, 2'b01, 1, 1'b0, 1'b0);
    runTxn("hold", 2'b00, 2'b10, 50, 1'b0, 1'b0);

    // Randomized presses, ack latencies and presses while busy
    for (int r = 0; r < 12; r++) begin
      ackDelay = $urandom_range(1, 4);
      runTxn($sformatf("rnd%0d", r), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Load ack never arrives: abort after the timeout, no operand display
    ackDelay = 2;
    ackMask  = 7'b100_1111;
    expErr   = 1'b1;
    runTxn("tmo", 2'b01, 2'b00, 1, 1'b0, 1'b1);
    checkVal("tmo_len", 32'(lastLoadLen), 32'(TMO));
    ackMask = 7'h7f;
    runTxn("post_tmo_dig", 2'b00, 2'b01, 1, 1'b0, 1'b0);
    runTxn("post_tmo_load", 2'b10, 2'b00, 2, 1'b0, 1'b0);

    // Reset during the operand display restarts the init sequence
    ackDelay  = 3;
    load_btn  = 2'b10;
    @(negedge clock);
    load_btn  = '0;
    n = 0;
    while (opdisp_req !== 2'b10 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkVal("mid_opd", 32'(opdisp_req), 32'(2'b10));
    #2;
    reset = 1'b1;
    #1;
    checkVal("mid_rst_reqs", 32'({init_req, load_req, opdisp_req, digit_req}), 32'(0));
    checkVal("mid_rst_state", 32'(state_dbg), 32'(0));
    checkVal("mid_rst_busy", 32'(busy), 32'(1));
    checkVal("mid_rst_err", 32'(error), 32'(0));
    expErr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    obs.delete();
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkVal("reinit_req", 32'(init_req), 32'(1));
    @(negedge clock);
    waitIdle("reinit");
    repeat (3) @(negedge clock);
    expQ.delete();
    expQ.push_back(KIND_INIT * 256 + 1);
    compareObs("reinit");
    runTxn("final", 2'b01, 2'b10, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
